// File: rtl/arp_tx_ctrl_pkg.sv
// Shared constants for the ARP transmit scheduler: FSM encoding, opcodes and the
// broadcast MAC.
package arp_tx_ctrl_pkg;

  typedef logic [1:0] arp_state_t;

  localparam arp_state_t ST_IDLE      = 2'd0;
  localparam arp_state_t ST_START     = 2'd1;
  localparam arp_state_t ST_WAIT_DONE = 2'd2;
  localparam arp_state_t ST_IFG       = 2'd3;

  localparam logic ARP_OPER_REQ   = 1'b0;
  localparam logic ARP_OPER_REPLY = 1'b1;

  localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

  // Bits needed to hold the values 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arp_tx_ctrl_if.sv
// Request/launch signal bundle between the ARP scheduler and its neighbours
// (RX path, UDP path, ARP payload generator).
interface arp_tx_ctrl_if;

  logic        arp_reply_req;
  logic [47:0] arp_reply_mac;
  logic [31:0] arp_reply_ip;
  logic        arp_resolve_req;
  logic [31:0] arp_resolve_ip;
  logic        arp_resolved;
  logic        tx_frame_busy;
  logic        arp_data_tx_done;

  logic        eth_header_arp_tx_start;
  logic        arp_oper;
  logic [47:0] mac_d_addr;
  logic [31:0] ip_d_addr;
  logic        arp_busy;
  logic        arp_fail;
  logic        arp_drop;
  logic        arp_tx_err;

  modport master (
    output arp_reply_req, arp_reply_mac, arp_reply_ip,
    output arp_resolve_req, arp_resolve_ip, arp_resolved,
    output tx_frame_busy, arp_data_tx_done,
    input  eth_header_arp_tx_start, arp_oper, mac_d_addr, ip_d_addr,
    input  arp_busy, arp_fail, arp_drop, arp_tx_err
  );

  modport slave (
    input  arp_reply_req, arp_reply_mac, arp_reply_ip,
    input  arp_resolve_req, arp_resolve_ip, arp_resolved,
    input  tx_frame_busy, arp_data_tx_done,
    output eth_header_arp_tx_start, arp_oper, mac_d_addr, ip_d_addr,
    output arp_busy, arp_fail, arp_drop, arp_tx_err
  );

endinterface

// File: rtl/arp_tx_ctrl_retry_timer.sv
// Retransmission timer for the pending resolve request: down-counter, retry count
// and exhaustion detect.
module arp_retry_timer
  import arp_tx_ctrl_pkg::*;
#(
  parameter int RETRY_CYCLES = 125_000_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic launch,
  output logic retry_due,
  output logic retry_exh
);

  localparam int TMR_W = cnt_w(RETRY_CYCLES);
  localparam int CNT_W = cnt_w(MAX_RETRY + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RETRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_RETRY);

  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] retry_cnt;
  logic             sent;
  logic             tmr_zero;

  // retry_cnt only advances on retransmissions; the first send just marks 'sent'.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr       <= '0;
      retry_cnt <= '0;
      sent      <= 1'b0;
    end else if (clr) begin
      tmr       <= '0;
      retry_cnt <= '0;
      sent      <= 1'b0;
    end else if (launch) begin
      tmr  <= TMR_LOAD;
      sent <= 1'b1;
      if (sent) retry_cnt <= retry_cnt + 1'b1;
    end else if (!tmr_zero) begin
      tmr <= tmr - 1'b1;
    end
  end

  assign tmr_zero  = (tmr == '0);
  assign retry_due = tmr_zero && (!sent || retry_cnt != CNT_MAX);
  assign retry_exh = tmr_zero && sent && (retry_cnt == CNT_MAX);

endmodule

// File: rtl/arp_tx_ctrl.sv
// ARP frame scheduler for the gmii_tx_clk domain: queues replies and resolve
// requests, launches one frame at a time, enforces IFG and watches for completion.
module arp_tx_ctrl
  import arp_tx_ctrl_pkg::*;
#(
  parameter int RETRY_CYCLES = 125_000_000,
  parameter int MAX_RETRY    = 3,
  parameter int IFG_CYCLES   = 12,
  parameter int DONE_TIMEOUT = 2048
) (
  input logic          aclk,
  input logic          areset,
  arp_tx_ctrl_if.slave arp
);

  localparam int WD_W  = cnt_w(DONE_TIMEOUT);
  localparam int IFG_W = cnt_w(IFG_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(DONE_TIMEOUT - 1);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

  arp_state_t  state;
  logic        reply_pend, reply_refill, job_reply, req_pend;
  logic [47:0] reply_mac, mac_q;
  logic [31:0] reply_ip, req_ip, ip_q;
  logic        oper_q, fail_q, drop_q, err_q;
  logic [WD_W-1:0]  wd_cnt;
  logic [IFG_W-1:0] ifg_cnt;
  logic        retry_due, retry_exh, retry_clr;
  logic        resolve_take, fail_now, load, load_reply, load_req;

  always_comb begin
    resolve_take = arp.arp_resolve_req && (!req_pend || arp.arp_resolve_ip != req_ip);
    fail_now     = req_pend && retry_exh && !arp.arp_resolved && !resolve_take;
    load         = (state == ST_IDLE) && !arp.tx_frame_busy &&
                   (reply_pend || (req_pend && retry_due));
    load_reply   = load && reply_pend;
    load_req     = load && !reply_pend;
    retry_clr    = resolve_take || arp.arp_resolved || fail_now;
  end

  arp_retry_timer #(
    .RETRY_CYCLES (RETRY_CYCLES),
    .MAX_RETRY    (MAX_RETRY)
  ) u_retry (
    .clk       (aclk),
    .rst       (areset),
    .clr       (retry_clr),
    .launch    (load_req),
    .retry_due (retry_due),
    .retry_exh (retry_exh)
  );

  // Request slots. A reply that lands in the load cycle must survive the START clear.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      reply_pend   <= 1'b0;
      reply_mac    <= '0;
      reply_ip     <= '0;
      reply_refill <= 1'b0;
      drop_q       <= 1'b0;
      req_pend     <= 1'b0;
      req_ip       <= '0;
      fail_q       <= 1'b0;
    end else begin
      drop_q       <= arp.arp_reply_req && reply_pend;
      reply_refill <= load_reply && arp.arp_reply_req;
      if (arp.arp_reply_req) begin
        reply_pend <= 1'b1;
        reply_mac  <= arp.arp_reply_mac;
        reply_ip   <= arp.arp_reply_ip;
      end else if (state == ST_START && job_reply && !reply_refill) begin
        reply_pend <= 1'b0;
      end

      fail_q <= fail_now;
      if (resolve_take) begin
        req_pend <= 1'b1;
        req_ip   <= arp.arp_resolve_ip;
      end else if (arp.arp_resolved || fail_now) begin
        req_pend <= 1'b0;
      end
    end
  end

  // Launch FSM: IDLE -> START -> WAIT_DONE -> IFG -> IDLE.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      job_reply <= 1'b0;
      oper_q    <= 1'b0;
      mac_q     <= '0;
      ip_q      <= '0;
      wd_cnt    <= '0;
      ifg_cnt   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      ifg_cnt <= (state == ST_IFG) ? ifg_cnt + 1'b1 : '0;
      if (load) wd_cnt <= '0;
      else if (state == ST_START || state == ST_WAIT_DONE) wd_cnt <= wd_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (load) begin
            state     <= ST_START;
            job_reply <= load_reply;
            oper_q    <= load_reply ? ARP_OPER_REPLY : ARP_OPER_REQ;
            mac_q     <= load_reply ? reply_mac : MAC_BROADCAST;
            ip_q      <= load_reply ? reply_ip : req_ip;
          end
        end
        ST_START: state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (arp.arp_data_tx_done) begin
            state <= ST_IFG;
          end else if (wd_cnt == WD_LAST) begin
            state <= ST_IFG;
            err_q <= 1'b1;
          end
        end
        default: begin
          if (ifg_cnt == IFG_LAST) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign arp.eth_header_arp_tx_start = (state == ST_START);
  assign arp.arp_busy                = (state != ST_IDLE);
  assign arp.arp_oper                = oper_q;
  assign arp.mac_d_addr              = mac_q;
  assign arp.ip_d_addr               = ip_q;
  assign arp.arp_fail                = fail_q;
  assign arp.arp_drop                = drop_q;
  assign arp.arp_tx_err              = err_q;

endmodule
